// File: rtl/bubble_sort_pkg.sv
// Shared types and helpers for the in-place bubble sort controller.
// The default widths match memory_block so both sides can share them.
package bubble_sort_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    CMP,
    WR_LO,
    WR_HI,
    ADV,
    DONE
  } state_t;

  // Signed compare flips the sign bit so a plain unsigned compare orders two's-complement values.
  function automatic logic elem_gt(input logic [63:0] x, input logic [63:0] y,
                                   input int w, input logic is_signed);
    logic [63:0] flip;
    flip = is_signed ? (64'd1 << (w - 1)) : 64'd0;
    return (x ^ flip) > (y ^ flip);
  endfunction

endpackage

// File: rtl/bubble_sort_ctrl.sv
// Sorts a contiguous region of a single-port memory in place, ascending, by bubble sort.
// Memory pins are registered and set for the state being entered, so they are Moore outputs.
//
// state | meaning
// IDLE  | waiting for start
// RD_A  | read element i into a
// RD_B  | read element i+1 into b
// CMP   | decide whether the pair is out of order
// WR_LO | write b to element i
// WR_HI | write a to element i+1, count the swap
// ADV   | step to next pair, next pass, or finish
// DONE  | one-cycle done pulse
module bubble_sort_ctrl
  import bubble_sort_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit SIGNED_CMP = 1'b0,
  parameter int SWAP_W     = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic [SWAP_W-1:0]     swap_count,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] i;
  logic [ADDR_WIDTH-1:0] pass_end;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  swapped;

  logic [ADDR_WIDTH-1:0] addr_i;
  logic [ADDR_WIDTH-1:0] addr_i1;
  logic [ADDR_WIDTH:0]   i_inc;
  logic                  a_gt_b;

  assign addr_i  = base + i;
  assign addr_i1 = base + i + 1'b1;
  assign i_inc   = {1'b0, i} + 1'b1;
  assign a_gt_b  = elem_gt(64'(a), 64'(b), DATA_WIDTH, SIGNED_CMP);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      swap_count <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      base       <= '0;
      i          <= '0;
      pass_end   <= '0;
      a          <= '0;
      b          <= '0;
      swapped    <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (len < (ADDR_WIDTH+1)'(2)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              base       <= base_addr;
              pass_end   <= ADDR_WIDTH'(len - 1'b1);
              i          <= '0;
              swapped    <= 1'b0;
              swap_count <= '0;
              state      <= RD_A;
              mem_read   <= 1'b1;
              mem_addr   <= base_addr;
            end
          end
        end
        RD_A: begin
          a        <= mem_rdata;
          state    <= RD_B;
          mem_read <= 1'b1;
          mem_addr <= addr_i1;
        end
        RD_B: begin
          b     <= mem_rdata;
          state <= CMP;
        end
        CMP: begin
          if (a_gt_b) begin
            swapped   <= 1'b1;
            state     <= WR_LO;
            mem_write <= 1'b1;
            mem_addr  <= addr_i;
            mem_wdata <= b;
          end else begin
            state <= ADV;
          end
        end
        WR_LO: begin
          state     <= WR_HI;
          mem_write <= 1'b1;
          mem_addr  <= addr_i1;
          mem_wdata <= a;
        end
        WR_HI: begin
          if (swap_count != '1) swap_count <= swap_count + 1'b1;
          state <= ADV;
        end
        ADV: begin
          if (i_inc < {1'b0, pass_end}) begin
            i        <= i + 1'b1;
            state    <= RD_A;
            mem_read <= 1'b1;
            mem_addr <= addr_i1;
          end else if (!swapped || pass_end == ADDR_WIDTH'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            pass_end <= pass_end - 1'b1;
            i        <= '0;
            swapped  <= 1'b0;
            state    <= RD_A;
            mem_read <= 1'b1;
            mem_addr <= base;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
